// File: rtl/regfile_sb.sv
// regfile_sb
//
// General-purpose register file for the CPU core. It sits between decode
// (operand read and issue) and write-back.
//
// Features:
//   - Two combinational read ports.
//   - One write-back port, bypassed to the read ports in the same cycle.
//   - A per-register busy scoreboard: set on issue, cleared on write-back.
//   - A sequential clear engine that zeroes one entry per cycle.
//
// Parameters:
//   DATA_W    register width in bits
//   ADDR_W    register address width; the file holds 2**ADDR_W entries
//   ZERO_REG  when 1, register 0 reads as zero, ignores writes and issues,
//             and is always ready
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   rs1_addr   read port 1 address
//   rs1_data   read port 1 data (combinational)
//   rs1_ready  read port 1 operand valid (no pending producer)
//   rs2_addr   read port 2 address
//   rs2_data   read port 2 data (combinational)
//   rs2_ready  read port 2 operand valid
//   wb_we      write-back enable
//   wb_addr    write-back destination
//   wb_data    write-back data
//   iss_valid  an instruction with a destination issued this cycle
//   iss_rd     destination of the issued instruction; marked busy
//   clr_req    start a sequential clear (sampled while idle)
//   clr_busy   clear engine active
//   clr_done   one-cycle pulse after the last entry has been cleared
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs1_ready,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs2_ready,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Last index visited by the clear engine.
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    // With a hardwired zero register the clear starts at entry 1.
    localparam logic [ADDR_W-1:0] CLR_START = ADDR_W'((ZERO_REG != 0) ? 1 : 0);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] counter;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic idle;
    logic wb_ok;
    logic iss_ok;

    assign idle     = (state == IDLE);
    assign clr_busy = (state == CLEAR);

    // Write-back and issue only act while idle, and never on the
    // hardwired zero register.
    assign wb_ok  = idle && wb_we && !((ZERO_REG != 0) && (wb_addr == '0));
    assign iss_ok = idle && iss_valid && !((ZERO_REG != 0) && (iss_rd == '0));

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Priority: hardwired zero, then the write-back bypass (only while
    // idle), then the stored value.
    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        if (is_zero(a)) begin
            return '0;
        end else if (idle && wb_we && (wb_addr == a)) begin
            return wb_data;
        end else begin
            return regs[a];
        end
    endfunction

    // A matching write-back this cycle satisfies a pending producer
    // immediately. Nothing is ready during a clear except the zero register.
    function automatic logic read_ready(input logic [ADDR_W-1:0] a);
        return is_zero(a) || (idle && (!busy[a] || (wb_we && (wb_addr == a))));
    endfunction

    assign rs1_data  = read_data(rs1_addr);
    assign rs1_ready = read_ready(rs1_addr);
    assign rs2_data  = read_data(rs2_addr);
    assign rs2_ready = read_ready(rs2_addr);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave CLEAR once the last index has been written.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (counter == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The clear counter holds at the last index rather than wrapping; it is
    // reloaded whenever a new clear starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (idle && clr_req) begin
            counter <= CLR_START;
        end else if (clr_busy && (counter != LAST_IDX)) begin
            counter <= counter + 1'b1;
        end
    end

    // The done pulse is registered so that it appears in the first idle
    // cycle after the final clear write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_done <= 1'b0;
        end else begin
            clr_done <= clr_busy && (counter == LAST_IDX);
        end
    end

    // Storage array: write-back while idle, one zeroed entry per clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_busy) begin
            regs[counter] <= '0;
        end else if (wb_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard. The set is applied after the clear, so an issue to the same
    // register as the write-back leaves it busy (newer producer). Starting a
    // clear drops every pending producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (idle && clr_req) begin
            busy <= '0;
        end else begin
            if (wb_ok) busy[wb_addr] <= 1'b0;
            if (iss_ok) busy[iss_rd] <= 1'b1;
        end
    end

endmodule
